// File: rtl/count_tick_ctrl_pkg.sv
// count_tick_ctrl_pkg: shared defaults and direction encoding for the tick controller
package count_tick_ctrl_pkg;
    localparam int TICK_DIV_DEF     = 50_000_000;
    localparam int DEBOUNCE_CYC_DEF = 500_000;
    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
endpackage

// File: rtl/count_tick_ctrl_if.sv
// count_tick_ctrl_if: raw buttons in, counter control levels/tick out
//  btn_dir/btn_pause/btn_step : raw async pushbuttons, active-high
//  enable                     : one-cycle tick to the digit counter
//  up_down                    : direction level, 1 = up
//  running                    : 1 = free-running, 0 = paused
interface count_tick_ctrl_if;
    logic btn_dir;
    logic btn_pause;
    logic btn_step;
    logic enable;
    logic up_down;
    logic running;
    modport master (output btn_dir, btn_pause, btn_step, input enable, up_down, running);
    modport slave (input btn_dir, btn_pause, btn_step, output enable, up_down, running);
endinterface

// File: rtl/count_tick_ctrl_btn_debounce.sv
// btn_debounce: 2-flop sync, stable-count debounce and registered press pulse for one button
//  clk, rst : clock and synchronous active-high reset
//  btn_raw  : raw asynchronous button level
//  level    : debounced button level
//  press    : one-cycle pulse on each debounced rising edge
module btn_debounce
    import count_tick_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC);
    logic sync1, sync2, level_q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            // accept the new level only after DEBOUNCE_CYC consecutive mismatching samples
            if (sync2 == level) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else cnt <= cnt + 1'b1;
            level_q <= level;
            press   <= level & ~level_q;
        end
    end
endmodule

// File: rtl/count_tick_ctrl.sv
// count_tick_ctrl: button-driven run/pause, single-step and direction control with prescaled enable tick
//  clk, rst : clock and synchronous active-high reset
//  bus      : slave side of count_tick_ctrl_if (raw buttons in; enable/up_down/running out, all registered)
module count_tick_ctrl
    import count_tick_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    count_tick_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    logic dir_press, pause_press, step_press;
    logic enable_q, running_q, terminal, enable_d;
    logic [PW-1:0] pre;
    dir_e dir_q;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dir (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_dir), .level(), .press(dir_press)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pause (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_pause), .level(), .press(pause_press)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_step), .level(), .press(step_press)
    );

    assign terminal = running_q && pre == PW'(TICK_DIV - 1);
    // a step right after a final tick is suppressed so enable never stays high two cycles
    assign enable_d = terminal || (!running_q && step_press && !pause_press && !enable_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q  <= 1'b0;
            running_q <= 1'b0;
            dir_q     <= DIR_UP;
            pre       <= '0;
        end else begin
            enable_q <= enable_d;
            if (dir_press) dir_q <= dir_e'(~dir_q);
            if (pause_press) running_q <= ~running_q;
            pre <= (!running_q || pause_press || terminal) ? '0 : pre + 1'b1;
        end
    end

    assign bus.enable  = enable_q;
    assign bus.up_down = dir_q;
    assign bus.running = running_q;
endmodule

// File: tb/tb_count_tick_ctrl.sv
// tb_count_tick_ctrl: directed and randomized checks of count_tick_ctrl against a behavioural model
module tb_count_tick_ctrl;
    localparam int TD = 5;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    count_tick_ctrl_if bus();
    count_tick_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYC(DC)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // model: button levels accepted after DC consecutive disagreeing synchronised samples;
    // ticks every TD cycles measured from the cycle running rose
    int n, run_start;
    logic m_en, m_ud, m_run;
    logic [15:0] hist [3];
    logic lvl [3];
    logic rd1 [3];
    logic rd2 [3];

    task automatic model_edge(input logic r, input logic [2:0] raw);
        logic ev [3];
        logic diff, en;
        if (r) begin
            n = 0; run_start = 0; m_en = 1'b0; m_ud = 1'b1; m_run = 1'b0;
            for (int b = 0; b < 3; b++) begin
                hist[b] = '0; lvl[b] = 1'b0; rd1[b] = 1'b0; rd2[b] = 1'b0;
            end
            return;
        end
        for (int b = 0; b < 3; b++) begin
            ev[b] = rd2[b];
            rd2[b] = rd1[b];
            hist[b] = {hist[b][14:0], raw[b]};
            diff = 1'b1;
            for (int k = 2; k < DC + 2; k++) if (hist[b][k] == lvl[b]) diff = 1'b0;
            rd1[b] = diff & ~lvl[b];
            if (diff) lvl[b] = ~lvl[b];
        end
        en = (m_run && (n - run_start) % TD == 0) || (!m_run && ev[2] && !ev[1] && !m_en);
        if (ev[0]) m_ud = ~m_ud;
        if (ev[1]) begin
            m_run = ~m_run;
            run_start = n;
        end
        m_en = en;
        n++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(rst, {bus.btn_step, bus.btn_pause, bus.btn_dir});
        #1;
    endtask

    task automatic set_btn(input logic d, input logic p, input logic s);
        bus.btn_dir = d;
        bus.btn_pause = p;
        bus.btn_step = s;
    endtask

    task automatic do_reset();
        set_btn(0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_btn(0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.enable, bus.up_down, bus.running} !== 3'b010)
            $display("FAIL reset_state got=%b exp=010", {bus.enable, bus.up_down, bus.running});
        else passed++;
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if ({bus.enable, bus.up_down, bus.running} !== 3'b010)
                $display("FAIL idle cyc=%0d got=%b exp=010", i, {bus.enable, bus.up_down, bus.running});
            else passed++;
        end
    endtask

    task automatic test_run_ticks();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            set_btn(0, i >= 10 && i < 20, 0);
            tick();
            checks++;
            if ({bus.enable, bus.up_down, bus.running} !== {m_en, m_ud, m_run})
                $display("FAIL run_model cyc=%0d got=%b exp=%b", i, {bus.enable, bus.up_down, bus.running}, {m_en, m_ud, m_run});
            else passed++;
            if (i == 16 || i == 17) begin
                checks++;
                if (bus.running !== (i == 17)) $display("FAIL run_rise cyc=%0d got=%b exp=%b", i, bus.running, i == 17);
                else passed++;
            end
            if (i >= 18) begin
                checks++;
                if (bus.enable !== (i >= 22 && (i - 22) % TD == 0))
                    $display("FAIL run_tick cyc=%0d got=%b exp=%b", i, bus.enable, i >= 22 && (i - 22) % TD == 0);
                else passed++;
            end
        end
    endtask

    task automatic test_dir_bounce();
        logic [5:0] bounce = 6'b011101;
        for (int j = 0; j < 30; j++) begin
            set_btn(j < 6 ? bounce[j] : (j >= 10 && j < 16), 0, 0);
            tick();
            checks++;
            if ({bus.enable, bus.up_down, bus.running} !== {m_en, m_ud, m_run})
                $display("FAIL dir_model cyc=%0d got=%b exp=%b", j, {bus.enable, bus.up_down, bus.running}, {m_en, m_ud, m_run});
            else passed++;
            checks++;
            if (bus.up_down !== (j < 17)) $display("FAIL dir_flip cyc=%0d got=%b exp=%b", j, bus.up_down, j < 17);
            else passed++;
            checks++;
            if (bus.enable !== ((n - 1 - 22) % TD == 0))
                $display("FAIL dir_spacing cyc=%0d got=%b exp=%b", j, bus.enable, (n - 1 - 22) % TD == 0);
            else passed++;
        end
    endtask

    task automatic test_step();
        do_reset();
        for (int j = 0; j < 50; j++) begin
            set_btn(0, j >= 20 && j < 26, (j >= 5 && j < 11) || (j >= 30 && j < 36));
            tick();
            checks++;
            if ({bus.enable, bus.up_down, bus.running} !== {m_en, m_ud, m_run})
                $display("FAIL step_model cyc=%0d got=%b exp=%b", j, {bus.enable, bus.up_down, bus.running}, {m_en, m_ud, m_run});
            else passed++;
            checks++;
            if (bus.enable !== (j == 12 || (j >= 32 && (j - 32) % TD == 0)))
                $display("FAIL step_pulse cyc=%0d got=%b exp=%b", j, bus.enable, j == 12 || (j >= 32 && (j - 32) % TD == 0));
            else passed++;
        end
    endtask

    task automatic test_pause_tick();
        do_reset();
        for (int j = 0; j < 70; j++) begin
            set_btn(0, j < 6 || (j >= 20 && j < 26), 0);
            tick();
            checks++;
            if ({bus.enable, bus.up_down, bus.running} !== {m_en, m_ud, m_run})
                $display("FAIL ptick_model cyc=%0d got=%b exp=%b", j, {bus.enable, bus.up_down, bus.running}, {m_en, m_ud, m_run});
            else passed++;
            checks++;
            if ({bus.enable, bus.running} !== {j == 12 || j == 17 || j == 22 || j == 27, j >= 7 && j < 27})
                $display("FAIL ptick_direct cyc=%0d got=%b exp=%b", j, {bus.enable, bus.running},
                         {j == 12 || j == 17 || j == 22 || j == 27, j >= 7 && j < 27});
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int j = 0; j < 112; j++) begin
            set_btn(j < 6, j < 6, 0);
            rst = (j == 11);
            tick();
            checks++;
            if ({bus.enable, bus.up_down, bus.running} !== {m_en, m_ud, m_run})
                $display("FAIL rmid_model cyc=%0d got=%b exp=%b", j, {bus.enable, bus.up_down, bus.running}, {m_en, m_ud, m_run});
            else passed++;
            if (j == 10 || j >= 11) begin
                checks++;
                if ({bus.enable, bus.up_down, bus.running} !== (j == 10 ? 3'b001 : 3'b010))
                    $display("FAIL rmid_direct cyc=%0d got=%b exp=%b", j, {bus.enable, bus.up_down, bus.running},
                             j == 10 ? 3'b001 : 3'b010);
                else passed++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int rem [3];
        logic cur [3];
        do_reset();
        for (int b = 0; b < 3; b++) begin
            rem[b] = 0;
            cur[b] = 1'b0;
        end
        for (int j = 0; j < 4000; j++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    cur[b] = ~cur[b];
                    rem[b] = $urandom_range(1, 9);
                end
                rem[b]--;
            end
            set_btn(cur[0], cur[1], cur[2]);
            rst = ($urandom_range(0, 399) == 0);
            tick();
            checks++;
            if ({bus.enable, bus.up_down, bus.running} !== {m_en, m_ud, m_run})
                $display("FAIL rand_model cyc=%0d got=%b exp=%b", j, {bus.enable, bus.up_down, bus.running}, {m_en, m_ud, m_run});
            else passed++;
        end
        rst = 1'b0;
    endtask

    initial begin
        set_btn(0, 0, 0);
        test_reset();
        test_run_ticks();
        test_dir_bounce();
        test_step();
        test_pause_tick();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
